// File: rtl/if_pkg.sv
// Shared types and constants for the IF stage fetch front-end.
package if_pkg;

  localparam int XLEN = 32;
  localparam int QDEPTH = 2;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory, redirect and ID-handshake bundle of the fetch unit.
// master = fetch unit side, slave = memory/EX/ID side.
interface if_fetch_unit_if #(parameter int ADDR_W = 7);
  import if_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_instr;
  logic [XLEN-1:0]   id_pc;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/if_fetch_queue.sv
// Two-entry FIFO of {pc, instr}; head visible combinationally, 1-cycle write-to-head.
// Caller must not push when full without a pop; flush wins over push and pop.
module if_fetch_queue
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdat,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem [QDEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdat;
  end

  assign full  = (count == 2'(QDEPTH));
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage PC generator + fetch queue; fetch-to-ID 1 cycle, redirect-to-ID 2 cycles.
// Stalls PC when the queue is full and ID is not ready; redirects flush the queue.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              ADDR_W   = 7,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  if_fetch_unit_if.master bus,
  output logic          misalign_err
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            err_nxt;
  logic            push, pop, flush;
  logic            full, empty;
  fetch_entry_t    head;
  fetch_entry_t    wdat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      misalign_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    err_nxt   = misalign_err;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = bus.id_valid && bus.id_ready;
    case (state)
      BOOT, RUN: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          if (|bus.redirect_pc[1:0]) begin
            err_nxt   = 1'b1;
            state_nxt = ERR;
          end else begin
            pc_nxt    = bus.redirect_pc;
            state_nxt = RUN;
          end
        end else if (state == BOOT) begin
          state_nxt = RUN;
        end else begin
          push = fetch_en && (!full || pop);
          if (push) pc_nxt = pc + 32'd4;
        end
      end
      ERR: flush = 1'b1;
      default: begin
        flush     = 1'b1;
        state_nxt = BOOT;
      end
    endcase
  end

  assign wdat = '{pc: pc, instr: bus.imem_rdata};

  if_fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdat  (wdat),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.imem_addr = pc[ADDR_W+1:2];
  assign bus.id_valid  = !empty;
  assign bus.id_instr  = bus.id_valid ? head.instr : '0;
  assign bus.id_pc     = bus.id_valid ? head.pc    : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_en;
  logic misalign_err;

  if_fetch_unit_if #(.ADDR_W(7)) bus ();

  if_fetch_unit #(.ADDR_W(7), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .bus          (bus.master),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [128];
  assign bus.imem_rdata = mem[bus.imem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queue of accepted fetches plus a byte PC.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  bit          merr;
  bit          mboot;

  typedef struct {
    logic        fe, rdy, rv;
    logic [31:0] rp;
    logic        ev;
    logic [31:0] epc, einstr;
    logic [6:0]  eaddr;
    logic        eerr;
  } vec_t;
  vec_t tbl [16];

  function automatic vec_t mk(logic fe, logic rdy, logic rv, logic [31:0] rp, logic ev,
                              logic [31:0] epc, logic [31:0] einstr, logic [6:0] eaddr,
                              logic eerr);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rp = rp; v.ev = ev;
    v.epc = epc; v.einstr = einstr; v.eaddr = eaddr; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = 32'h0;
    merr  = 1'b0;
    mboot = 1'b1;
  endtask

  task automatic check_model();
    logic        ev;
    logic [31:0] epc, ein;
    ev  = (mq.size() != 0);
    epc = ev ? mq[0].pc : 32'h0;
    ein = ev ? mq[0].instr : 32'h0;
    chk("id_valid", 32'(bus.id_valid), 32'(ev));
    chk("id_pc", bus.id_pc, epc);
    chk("id_instr", bus.id_instr, ein);
    chk("imem_addr", 32'(bus.imem_addr), 32'(mpc[8:2]));
    chk("misalign_err", 32'(misalign_err), 32'(merr));
  endtask

  task automatic model_edge();
    bit pop_m, push_m;
    if (merr) return;
    if (bus.redirect_valid) begin
      mq.delete();
      mboot = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) merr = 1'b1;
      else mpc = bus.redirect_pc;
    end else if (mboot) begin
      mboot = 1'b0;
    end else begin
      pop_m  = (mq.size() != 0) && bus.id_ready;
      push_m = fetch_en && ((mq.size() < 2) || pop_m);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back('{mpc, mem[mpc[8:2]]});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step();
    #1;
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    fetch_en           = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int          accepts;
    bit          have_last;
    logic [31:0] last_pc;

    tbl[0]  = mk(1, 1, 0, 32'h0,  0, 32'h0,  0,  7'd0,  0);
    tbl[1]  = mk(1, 1, 0, 32'h0,  0, 32'h0,  0,  7'd0,  0);
    tbl[2]  = mk(1, 0, 0, 32'h0,  1, 32'h0,  0,  7'd1,  0);
    tbl[3]  = mk(1, 0, 0, 32'h0,  1, 32'h0,  0,  7'd2,  0);
    tbl[4]  = mk(1, 0, 0, 32'h0,  1, 32'h0,  0,  7'd2,  0);
    tbl[5]  = mk(1, 0, 0, 32'h0,  1, 32'h0,  0,  7'd2,  0);
    tbl[6]  = mk(1, 0, 0, 32'h0,  1, 32'h0,  0,  7'd2,  0);
    tbl[7]  = mk(1, 1, 0, 32'h0,  1, 32'h0,  0,  7'd2,  0);
    tbl[8]  = mk(1, 1, 0, 32'h0,  1, 32'h4,  1,  7'd3,  0);
    tbl[9]  = mk(1, 0, 0, 32'h0,  1, 32'h8,  2,  7'd4,  0);
    tbl[10] = mk(1, 0, 1, 32'h40, 1, 32'h8,  2,  7'd4,  0);
    tbl[11] = mk(1, 1, 0, 32'h0,  0, 32'h0,  0,  7'd16, 0);
    tbl[12] = mk(1, 1, 0, 32'h0,  1, 32'h40, 16, 7'd17, 0);
    tbl[13] = mk(1, 1, 1, 32'h42, 1, 32'h44, 17, 7'd18, 0);
    tbl[14] = mk(1, 1, 0, 32'h0,  0, 32'h0,  0,  7'd18, 1);
    tbl[15] = mk(1, 1, 0, 32'h0,  0, 32'h0,  0,  7'd18, 1);

    for (int k = 0; k < 128; k++) mem[k] = 32'(k);

    @(posedge clk);
    #1;
    do_reset();

    // Stall fill, full-queue push+pop, redirect flush and misaligned redirect.
    for (int i = 0; i < 16; i++) begin
      fetch_en           = tbl[i].fe;
      bus.id_ready       = tbl[i].rdy;
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc    = tbl[i].rp;
      #1;
      chk($sformatf("vec%0d id_valid", i), 32'(bus.id_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d id_pc", i), bus.id_pc, tbl[i].epc);
      chk($sformatf("vec%0d id_instr", i), bus.id_instr, tbl[i].einstr);
      chk($sformatf("vec%0d imem_addr", i), 32'(bus.imem_addr), 32'(tbl[i].eaddr));
      chk($sformatf("vec%0d misalign_err", i), 32'(misalign_err), 32'(tbl[i].eerr));
      step();
    end

    // Reset clears the sticky error immediately.
    rst_n = 1'b0;
    #1;
    chk("rst misalign_err", 32'(misalign_err), 32'h0);
    chk("rst imem_addr", 32'(bus.imem_addr), 32'h0);
    do_reset();

    // Redirect in BOOT to the top of the address space; PC wraps to 0.
    fetch_en           = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #1;
    chk("wrap addr top", 32'(bus.imem_addr), 32'd127);
    chk("wrap valid gap", 32'(bus.id_valid), 32'h0);
    step();
    #1;
    chk("wrap addr zero", 32'(bus.imem_addr), 32'd0);
    chk("wrap pc top", bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap instr top", bus.id_instr, 32'd127);
    step();
    #1;
    chk("wrap pc zero", bus.id_pc, 32'h0);
    chk("wrap instr zero", bus.id_instr, 32'h0);
    step();

    // fetch_en toggling: one instruction every two cycles, contiguous PCs.
    accepts   = 0;
    have_last = 1'b0;
    last_pc   = 32'h0;
    for (int i = 0; i < 20; i++) begin
      fetch_en = (i % 2) != 0;
      #1;
      if (bus.id_valid && bus.id_ready) begin
        if (have_last) chk("toggle contiguous pc", bus.id_pc, last_pc + 32'd4);
        last_pc   = bus.id_pc;
        have_last = 1'b1;
        accepts++;
      end
      step();
    end
    chk("toggle accept count", 32'(accepts), 32'd10);
    chk("toggle queue busy", 32'(bus.id_valid), 32'h1);

    // Mid-cycle reset pulse zeroes outputs without waiting for a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst id_valid", 32'(bus.id_valid), 32'h0);
    chk("async rst id_pc", bus.id_pc, 32'h0);
    chk("async rst id_instr", bus.id_instr, 32'h0);
    chk("async rst imem_addr", 32'(bus.imem_addr), 32'h0);
    @(posedge clk);
    #1;
    do_reset();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 128; k++) mem[k] = $urandom;
    for (int i = 0; i < 3000; i++) begin
      if (merr && $urandom_range(0, 7) == 0) do_reset();
      fetch_en           = $urandom_range(0, 3) != 0;
      bus.id_ready       = $urandom_range(0, 2) != 0;
      bus.redirect_valid = $urandom_range(0, 11) == 0;
      bus.redirect_pc    = $urandom;
      if ($urandom_range(0, 9) != 0) bus.redirect_pc[1:0] = 2'b00;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
